// File: rtl/text_reader_pkg.sv
// Shared definitions for the text_reader slice: default string length, NUL code,
// one-hot FSM encoding and the index-width helper.
package text_reader_pkg;

    localparam int unsigned MAX_CHARS_DEF = 31;
    localparam logic [7:0]  CHAR_NUL      = 8'h00;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        SKIP = 4'b0010,
        SEND = 4'b0100,
        DONE = 4'b1000
    } state_t;

    // Index width, kept at least one bit so a single-character string still elaborates.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/text_byte_mux.sv
// Combinational byte selector: picks character `index` out of a packed string,
// character 0 at the MSB end.
module text_byte_mux
    import text_reader_pkg::*;
#(
    parameter int unsigned MAX_CHARS = MAX_CHARS_DEF,
    localparam int unsigned IDX_W    = idx_width(MAX_CHARS)
) (
    input  logic [8*MAX_CHARS-1:0] text,
    input  logic [IDX_W-1:0]       index,
    output logic [7:0]             sel_c
);

    always_comb begin
        sel_c = CHAR_NUL;
        for (int i = 0; i < MAX_CHARS; i++) begin
            if (index == IDX_W'(i)) begin
                sel_c = text[8*(MAX_CHARS-1-i) +: 8];
            end
        end
    end

endmodule

// File: rtl/text_reader.sv
// Serializes a captured packed string into bytes, skipping leading NUL padding
// and presenting one character per consumer `next`.
module text_reader
    import text_reader_pkg::*;
#(
    parameter int unsigned MAX_CHARS = MAX_CHARS_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [8*MAX_CHARS-1:0] text_in,
    input  logic                   load,
    input  logic                   next,
    output logic [7:0]             data_out,
    output logic                   valid,
    output logic                   done,
    output logic                   busy
);

    localparam int unsigned    IDX_W = idx_width(MAX_CHARS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(MAX_CHARS - 1);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [8*MAX_CHARS-1:0] text;
    logic [IDX_W-1:0]       sel_idx_c;
    logic [7:0]             sel_byte_c;
    logic                   at_last_c;

    // In SEND the mux looks one character ahead so data_out can update on the `next` edge.
    assign at_last_c = (idx == LAST);
    assign sel_idx_c = (state == SEND && !at_last_c) ? idx + IDX_W'(1) : idx;

    text_byte_mux #(.MAX_CHARS(MAX_CHARS)) u_mux (
        .text  (text),
        .index (sel_idx_c),
        .sel_c (sel_byte_c)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            text     <= '0;
            data_out <= CHAR_NUL;
            valid    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else if (load) begin
            state <= SKIP;
            idx   <= '0;
            text  <= text_in;
            valid <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b1;
        end else begin
            case (state)
                SKIP: begin
                    if (sel_byte_c != CHAR_NUL) begin
                        state    <= SEND;
                        data_out <= sel_byte_c;
                        valid    <= 1'b1;
                    end else if (at_last_c) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                SEND: begin
                    if (next) begin
                        if (at_last_c) begin
                            state    <= DONE;
                            data_out <= CHAR_NUL;
                            valid    <= 1'b0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            data_out <= sel_byte_c;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_reader.sv
// Self-checking bench for text_reader: directed and randomized strings compared
// against a byte-array model of the leading-NUL-stripping serializer.
module tb_text_reader;

    localparam int unsigned M = 31;

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic [8*M-1:0] text_in;
    logic           load;
    logic           next;
    logic [7:0]     data_out;
    logic           valid;
    logic           done;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] arr [M];
    logic [7:0] exp_q [$];
    int         exp_lat;
    logic [7:0] obs_q [$];
    int         obs_lat;
    int         obs_cyc;
    bit         obs_tmo;
    bit         obs_stable;

    always #5 Clk = ~Clk;

    text_reader #(.MAX_CHARS(M)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .text_in  (text_in),
        .load     (load),
        .next     (next),
        .data_out (data_out),
        .valid    (valid),
        .done     (done),
        .busy     (busy)
    );

    // Character 0 ends up at the MSB end.
    function automatic logic [8*M-1:0] pack(input logic [7:0] a [M]);
        logic [8*M-1:0] t;
        t = '0;
        for (int i = 0; i < M; i++) t = (t << 8) | {{(8*M-8){1'b0}}, a[i]};
        return t;
    endfunction

    // Reference: strip leading NULs, emit the rest verbatim.
    task automatic model();
        int f;
        f = M;
        exp_q = {};
        for (int i = M - 1; i >= 0; i--) if (arr[i] != 8'h00) f = i;
        for (int i = f; i < M; i++) exp_q.push_back(arr[i]);
        exp_lat = (f < M) ? f + 1 : M;
    endtask

    task automatic do_load(input logic [8*M-1:0] t);
        text_in = t;
        load    = 1'b1;
        @(negedge Clk);
        load    = 1'b0;
    endtask

    // Observes the stream after a load; hold=1 keeps next high continuously.
    task automatic collect(input bit hold);
        logic [7:0] d;
        int stall;
        obs_q = {}; obs_lat = 0; obs_cyc = 0; obs_tmo = 0; obs_stable = 1; next = 1'b0;
        while (!valid && !done && obs_lat < 100) begin
            @(negedge Clk);
            obs_lat++;
        end
        if (obs_lat >= 100) obs_tmo = 1;
        while (valid && obs_cyc < 200) begin
            d = data_out;
            obs_q.push_back(d);
            if (!hold) begin
                stall = $urandom_range(0, 2);
                repeat (stall) begin
                    @(negedge Clk);
                    obs_cyc++;
                    if (data_out !== d || valid !== 1'b1) obs_stable = 0;
                end
            end
            next = 1'b1;
            @(negedge Clk);
            obs_cyc++;
            if (!hold) next = 1'b0;
        end
        next = 1'b0;
        if (obs_cyc >= 200) obs_tmo = 1;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; load = 1'b1; next = 1'b1; text_in = {8{$urandom}};
        repeat (2) @(negedge Clk);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        load = 1'b0; next = 1'b0; Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_hi();
        logic [8*M-1:0] t;
        t = "HI";
        do_load(t);
        collect(0);
        checks++; if (obs_tmo || obs_lat != 30) begin errors++; $display("FAIL hi_latency got %0d want 30", obs_lat); end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL hi_count got %0d want 2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 8'h48 || obs_q[1] !== 8'h49) begin
                errors++; $display("FAIL hi_chars got %h %h want 48 49", obs_q[0], obs_q[1]);
            end
        end
        checks++; if (done !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL hi_done got done=%b valid=%b want 1 0", done, valid); end
        checks++; if (!obs_stable) begin errors++; $display("FAIL hi_stable got unstable want stable"); end
    endtask

    task automatic test_full_stream();
        for (int i = 0; i < M; i++) arr[i] = 8'($urandom_range(1, 255));
        model();
        do_load(pack(arr));
        collect(1);
        checks++; if (obs_tmo || obs_lat != 1) begin errors++; $display("FAIL full_latency got %0d want 1", obs_lat); end
        checks++; if (obs_cyc != M) begin errors++; $display("FAIL full_throughput got %0d want %0d", obs_cyc, M); end
        checks++; if (obs_q != exp_q) begin errors++; $display("FAIL full_chars got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
        checks++; if (done !== 1'b1 || data_out !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL full_end got done=%b data=%h busy=%b want 1 00 0", done, data_out, busy);
        end
        next = 1'b1; repeat (2) @(negedge Clk); next = 1'b0;
        checks++; if (done !== 1'b1 || valid !== 1'b0) begin errors++; $display("FAIL done_held got done=%b valid=%b want 1 0", done, valid); end
    endtask

    task automatic test_embedded_nul();
        for (int i = 0; i < M; i++) arr[i] = 8'h00;
        arr[M-3] = 8'h41; arr[M-1] = 8'h42;
        do_load(pack(arr));
        collect(0);
        checks++; if (obs_lat != M - 2) begin errors++; $display("FAIL emb_latency got %0d want %0d", obs_lat, M - 2); end
        checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL emb_count got %0d want 3", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 8'h41 || obs_q[1] !== 8'h00 || obs_q[2] !== 8'h42) begin
                errors++; $display("FAIL emb_chars got %h %h %h want 41 00 42", obs_q[0], obs_q[1], obs_q[2]);
            end
        end
    endtask

    task automatic test_all_zero();
        do_load('0);
        collect(0);
        checks++; if (obs_lat != M) begin errors++; $display("FAIL zero_latency got %0d want %0d", obs_lat, M); end
        checks++; if (obs_q.size() != 0 || done !== 1'b1) begin
            errors++; $display("FAIL zero_empty got %0d bytes done=%b want 0 bytes done=1", obs_q.size(), done);
        end
    endtask

    task automatic test_random();
        int nlead;
        for (int it = 0; it < 8; it++) begin
            nlead = $urandom_range(0, M);
            for (int i = 0; i < M; i++) arr[i] = (i < nlead) ? 8'h00 : 8'($urandom);
            if (nlead < M) arr[nlead] = 8'($urandom_range(1, 255));
            model();
            do_load(pack(arr));
            text_in = {8{$urandom}};
            collect(it[0]);
            checks++; if (obs_tmo || obs_lat != exp_lat) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", it, obs_lat, exp_lat); end
            checks++; if (obs_q != exp_q) begin errors++; $display("FAIL rand%0d_chars got %0d bytes want %0d", it, obs_q.size(), exp_q.size()); end
            checks++; if (!obs_stable || done !== 1'b1 || valid !== 1'b0) begin
                errors++; $display("FAIL rand%0d_end got stable=%b done=%b valid=%b want 1 1 0", it, obs_stable, done, valid);
            end
        end
    endtask

    task automatic test_restart();
        logic [8*M-1:0] t;
        int w;
        for (int i = 0; i < M; i++) arr[i] = 8'($urandom_range(1, 255));
        do_load(pack(arr));
        w = 0;
        while (!valid && w < 50) begin @(negedge Clk); w++; end
        next = 1'b1; @(negedge Clk);
        for (int i = 0; i < M; i++) arr[i] = (i < 5) ? 8'h00 : 8'($urandom_range(1, 255));
        model();
        t = pack(arr);
        text_in = t; load = 1'b1; next = 1'b1;
        @(negedge Clk);
        load = 1'b0; next = 1'b0;
        checks++; if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_state got valid=%b done=%b busy=%b want 0 0 1", valid, done, busy);
        end
        collect(0);
        checks++; if (obs_lat != exp_lat) begin errors++; $display("FAIL restart_latency got %0d want %0d", obs_lat, exp_lat); end
        checks++; if (obs_q != exp_q) begin errors++; $display("FAIL restart_chars got %0d bytes want %0d", obs_q.size(), exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int w;
        for (int i = 0; i < M; i++) arr[i] = 8'($urandom_range(1, 255));
        do_load(pack(arr));
        w = 0;
        while (!valid && w < 50) begin @(negedge Clk); w++; end
        Reset_n = 1'b0;
        @(negedge Clk);
        checks++; if (data_out !== 8'h00 || valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid got data=%h valid=%b done=%b busy=%b want 00 0 0 0", data_out, valid, done, busy);
        end
        Reset_n = 1'b1; next = 1'b1;
        repeat (3) @(negedge Clk);
        next = 1'b0;
        checks++; if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL idle_ignores_next got valid=%b busy=%b done=%b want 0 0 0", valid, busy, done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        load = 1'b0; next = 1'b0; text_in = '0; Reset_n = 1'b0;
        test_reset();
        test_hi();
        test_full_stream();
        test_embedded_nul();
        test_all_zero();
        test_random();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
